// File: rtl/mul_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_pkg                                                       |
// | Brief    : Shared widths, FSM state type and saturation constant.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package mul_pkg;

  localparam int DEF_RES_W = 64;
  localparam int DEF_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  localparam logic [DEF_RES_W-1:0] SAT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/mul_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_accumulator_if                                            |
// | Brief    : Job control, product stream and result handshake bundle.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface mul_accumulator_if #(
  parameter int RES_W = 64,
  parameter int LEN_W = 16
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic [RES_W-1:0] res;
  logic             val;
  logic             overflow;
  logic [RES_W-1:0] acc_out;
  logic             acc_val;
  logic             acc_ovf;
  logic             out_ready;
  logic             busy;
  logic [LEN_W-1:0] count;

  modport master (
    output start, len, res, val, overflow, out_ready,
    input  acc_out, acc_val, acc_ovf, busy, count
  );

  modport slave (
    input  start, len, res, val, overflow, out_ready,
    output acc_out, acc_val, acc_ovf, busy, count
  );

endinterface
`default_nettype wire

// File: rtl/mul_accumulator_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_add                                                       |
// | Brief    : Unsigned saturating adder with a force-saturate input.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sat_add #(
  parameter int RES_W = 64
) (
  input  logic [RES_W-1:0] a_i,
  input  logic [RES_W-1:0] b_i,
  input  logic             force_sat_i,
  output logic [RES_W-1:0] sum_o,
  output logic             sat_o
);

  logic [RES_W:0] wide_sum;

  assign wide_sum = {1'b0, a_i} + {1'b0, b_i};
  assign sat_o    = wide_sum[RES_W] | force_sat_i;
  assign sum_o    = sat_o ? {RES_W{1'b1}} : wide_sum[RES_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mul_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_accumulator                                               |
// | Brief    : Sums a programmed number of products into a saturating        |
// |            accumulator and presents the result behind valid/ready.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int RES_W = DEF_RES_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  mul_accumulator_if.slave  bus_io
);

  acc_state_t       state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             acc_val_q, acc_val_d;
  logic             busy_q, busy_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [LEN_W-1:0] count_inc;
  logic [RES_W-1:0] sum;
  logic             sat;

  assign count_inc = count_q + LEN_W'(1);

  sat_add #(
    .RES_W (RES_W)
  ) u_sat_add (
    .a_i         (acc_q),
    .b_i         (bus_io.res),
    .force_sat_i (bus_io.overflow),
    .sum_o       (sum),
    .sat_o       (sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          state_d = (bus_io.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (bus_io.val && (count_inc == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (acc_val_q && bus_io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are derived from the next state so they line up with it after the edge.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    len_d     = len_q;
    acc_val_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          len_d   = bus_io.len;
        end
      end
      ACCUM: begin
        if (bus_io.val) begin
          acc_d   = sum;
          ovf_d   = ovf_q | sat;
          count_d = count_inc;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      acc_val_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      len_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      acc_val_q <= acc_val_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      len_q     <= len_d;
    end
  end

  assign bus_io.acc_out = acc_q;
  assign bus_io.acc_ovf = ovf_q;
  assign bus_io.acc_val = acc_val_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_accumulator                                            |
// | Brief    : Directed jobs against a job-level reference model.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mul_accumulator;

  localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_accumulator_if #(.RES_W(64), .LEN_W(16)) bus ();

  mul_accumulator #(.RES_W(64), .LEN_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Job-level model: exact wide sum plus an "invalid product seen" flag.
  int           m_phase;   // 0 idle, 1 collecting, 2 result pending
  int           m_cnt;
  int           m_need;
  logic [127:0] m_tsum;
  bit           m_bad;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_need  <= 0;
      m_tsum  <= '0;
      m_bad   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_tsum  <= '0;
          m_bad   <= 1'b0;
          m_cnt   <= 0;
          m_need  <= int'(bus.len);
          m_phase <= (bus.len == 16'd0) ? 2 : 1;
        end
        1: if (bus.val) begin
          if (bus.overflow) m_bad <= 1'b1;
          else              m_tsum <= m_tsum + {64'd0, bus.res};
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_need) m_phase <= 2;
        end
        default: if (bus.out_ready) m_phase <= 0;
      endcase
    end
  end

  function automatic logic [63:0] exp_acc();
    if (m_bad || (m_tsum > {64'd0, MAXV})) return MAXV;
    return m_tsum[63:0];
  endfunction

  function automatic logic exp_ovf();
    return m_bad || (m_tsum > {64'd0, MAXV});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model acc_out", bus.acc_out, exp_acc());
      chk("model acc_ovf", 64'(bus.acc_ovf), 64'(exp_ovf()));
      chk("model acc_val", 64'(bus.acc_val), 64'(m_phase == 2));
      chk("model busy",    64'(bus.busy),    64'(m_phase != 0));
      chk("model count",   64'(bus.count),   64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    step();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] r, input logic o);
    bus.val      = 1'b1;
    bus.res      = r;
    bus.overflow = o;
    step();
    bus.val      = 1'b0;
    bus.overflow = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.res       = '0;
    bus.val       = 1'b0;
    bus.overflow  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("reset acc_out", bus.acc_out, 64'd0);
    chk("reset acc_val", 64'(bus.acc_val), 64'd0);
    chk("reset busy",    64'(bus.busy), 64'd0);
    chk("reset count",   64'(bus.count), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three small products, immediate acceptance
    start_job(16'd3);
    beat(64'd405, 1'b0);
    beat(64'd100, 1'b0);
    beat(64'd5, 1'b0);
    chk("t1 acc_val", 64'(bus.acc_val), 64'd1);
    chk("t1 acc_out", bus.acc_out, 64'd510);
    chk("t1 acc_ovf", 64'(bus.acc_ovf), 64'd0);
    step();
    chk("t1 acc_val drop", 64'(bus.acc_val), 64'd0);
    chk("t1 busy drop",    64'(bus.busy), 64'd0);

    // Carry saturation, then back-to-back clean job
    start_job(16'd2);
    beat(MAXV, 1'b0);
    beat(64'd1, 1'b0);
    chk("t2 acc_out sat", bus.acc_out, MAXV);
    chk("t2 acc_ovf",     64'(bus.acc_ovf), 64'd1);
    step();
    start_job(16'd1);
    beat(64'd7, 1'b0);
    chk("t2b acc_out", bus.acc_out, 64'd7);
    chk("t2b acc_ovf", 64'(bus.acc_ovf), 64'd0);
    step();

    // Multiplier-flagged overflow forces saturation
    start_job(16'd2);
    beat(64'd10, 1'b1);
    beat(64'd3, 1'b0);
    chk("t3 acc_out", bus.acc_out, MAXV);
    chk("t3 acc_ovf", 64'(bus.acc_ovf), 64'd1);
    chk("t3 count",   64'(bus.count), 64'd2);
    step();

    // Zero-length job and ignored val in IDLE/DONE
    beat(64'd55, 1'b0);
    chk("t4 idle count", 64'(bus.count), 64'd2);
    chk("t4 idle acc",   bus.acc_out, MAXV);
    bus.out_ready = 1'b0;
    start_job(16'd0);
    chk("t4 len0 acc_val", 64'(bus.acc_val), 64'd1);
    chk("t4 len0 acc_out", bus.acc_out, 64'd0);
    beat(64'd99, 1'b0);
    chk("t4 done count", 64'(bus.count), 64'd0);
    chk("t4 done acc",   bus.acc_out, 64'd0);
    bus.out_ready = 1'b1;
    step();

    // Backpressure hold; start during DONE ignored
    bus.out_ready = 1'b0;
    start_job(16'd1);
    beat(64'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t5 hold val", 64'(bus.acc_val), 64'd1);
      chk("t5 hold acc", bus.acc_out, 64'd9);
      bus.start = (i == 2);
      bus.len   = 16'd5;
      step();
    end
    bus.start = 1'b0;
    chk("t5 still val", 64'(bus.acc_val), 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("t5 released val", 64'(bus.acc_val), 64'd0);
    chk("t5 released busy", 64'(bus.busy), 64'd0);

    // Reset mid-job, then a fresh job
    start_job(16'd4);
    beat(64'd1, 1'b0);
    beat(64'd2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 rst acc_out", bus.acc_out, 64'd0);
    chk("t6 rst busy",    64'(bus.busy), 64'd0);
    chk("t6 rst count",   64'(bus.count), 64'd0);
    chk("t6 rst acc_val", 64'(bus.acc_val), 64'd0);
    start_job(16'd1);
    beat(64'd4, 1'b0);
    chk("t6 acc_out", bus.acc_out, 64'd4);
    step();
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
